// File: rtl/mci_pkg.sv
// Shared MCI types and helpers used by the SRAM arbiter and other MCI arbiters.
package mci_pkg;

    typedef enum logic {
        UNLOCKED,
        LOCKED
    } mci_sram_arb_state_e;

    localparam int MCI_SRAM_ARB_MAX_REQ = 4;
    localparam int MCI_REQ_IDX_W = $clog2(MCI_SRAM_ARB_MAX_REQ);

    typedef logic [MCI_REQ_IDX_W-1:0] mci_req_idx_t;

    // Wrapping increment of a requester index within 0..n-1.
    function automatic mci_req_idx_t mci_idx_inc(input mci_req_idx_t idx,
                                                 input int n);
        mci_req_idx_t r;
        if (int'(idx) + 1 >= n) begin
            r = '0;
        end else begin
            r = idx + 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mci_rr_pick.sv
// Rotate-priority pick: first set request at or above ptr, wrapping around.
module mci_rr_pick
    import mci_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  mci_req_idx_t ptr,
    output logic [N-1:0] gnt
);

    logic found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && req[i] &&
                    ((int'(ptr) + k == i) || (int'(ptr) + k == i + N))) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/mci_sram_arbiter.sv
// Round-robin single-port SRAM arbiter with grant lock, lock watchdog
// and read-response routing back to the issuing requester.
module mci_sram_arbiter
    import mci_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 18,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 1,
    parameter int LOCK_TO = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_we,
    input  logic [NUM_REQ-1:0]                 req_lock,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]     req_wdata,
    input  logic [NUM_REQ-1:0][DATA_W/8-1:0]   req_wstrb,
    output logic [NUM_REQ-1:0]                 rsp_valid,
    output logic [DATA_W-1:0]                  rsp_rdata,
    output logic                               sram_cs,
    output logic                               sram_we,
    output logic [ADDR_W-1:0]                  sram_addr,
    output logic [DATA_W-1:0]                  sram_wdata,
    output logic [DATA_W/8-1:0]                sram_wstrb,
    input  logic [DATA_W-1:0]                  sram_rdata,
    output logic                               lock_timeout
);

    localparam int CW = $clog2(LOCK_TO + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(LOCK_TO);

    mci_sram_arb_state_e state_q, state_d;
    mci_req_idx_t        owner_q, owner_d;
    mci_req_idx_t        rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]       to_cnt_q, to_cnt_d;

    logic [RD_LAT-1:0]                pv_q, pv_d;
    mci_req_idx_t [RD_LAT-1:0]        pid_q, pid_d;

    logic [NUM_REQ-1:0] own_hot;
    logic [NUM_REQ-1:0] lock_gnt;
    logic [NUM_REQ-1:0] pick_gnt;
    logic [NUM_REQ-1:0] gnt;
    mci_req_idx_t       pick_ptr;
    mci_req_idx_t       gnt_idx;
    logic               locked;
    logic               timeout;
    logic               beat;
    logic               gnt_lock;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            own_hot[i] = (owner_q == mci_req_idx_t'(i));
        end
    end

    assign locked   = (state_q == LOCKED);
    assign lock_gnt = own_hot & req_valid;

    // An owner that shows up on the expiry cycle keeps its lock.
    assign timeout  = locked && (to_cnt_q >= TO_MAX) && !(|lock_gnt);

    assign pick_ptr = timeout ? mci_idx_inc(owner_q, NUM_REQ) : rr_ptr_q;

    mci_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req (req_valid),
        .ptr (pick_ptr),
        .gnt (pick_gnt)
    );

    assign gnt          = (locked && !timeout) ? lock_gnt : pick_gnt;
    assign req_ready    = gnt;
    assign beat         = |gnt;
    assign gnt_lock     = |(gnt & req_lock);
    assign lock_timeout = timeout;

    always_comb begin
        gnt_idx    = '0;
        sram_we    = 1'b0;
        sram_addr  = '0;
        sram_wdata = '0;
        sram_wstrb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gnt_idx    = mci_req_idx_t'(i);
                sram_we    = req_we[i];
                sram_addr  = req_addr[i];
                sram_wdata = req_wdata[i];
                sram_wstrb = req_wstrb[i];
            end
        end
        sram_cs = beat;
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        to_cnt_d = to_cnt_q;
        if (timeout) begin
            state_d  = UNLOCKED;
            rr_ptr_d = mci_idx_inc(owner_q, NUM_REQ);
            to_cnt_d = '0;
        end else if (locked && to_cnt_q != TO_MAX) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
        if (beat) begin
            to_cnt_d = '0;
            if (gnt_lock) begin
                state_d = LOCKED;
                owner_d = gnt_idx;
            end else begin
                state_d  = UNLOCKED;
                rr_ptr_d = mci_idx_inc(gnt_idx, NUM_REQ);
            end
        end
    end

    always_comb begin
        pv_d     = '0;
        pid_d    = '0;
        pv_d[0]  = beat && !sram_we;
        pid_d[0] = gnt_idx;
        for (int s = 1; s < RD_LAT; s++) begin
            pv_d[s]  = pv_q[s-1];
            pid_d[s] = pid_q[s-1];
        end
    end

    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_valid[i] = pv_q[RD_LAT-1] &&
                           (pid_q[RD_LAT-1] == mci_req_idx_t'(i));
        end
        rsp_rdata = pv_q[RD_LAT-1] ? sram_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= UNLOCKED;
            owner_q  <= '0;
            rr_ptr_q <= '0;
            to_cnt_q <= '0;
            pv_q     <= '0;
            pid_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            to_cnt_q <= to_cnt_d;
            pv_q     <= pv_d;
            pid_q    <= pid_d;
        end
    end

endmodule
